// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store initiator for the data RAM
// Optional misalignment rejection: define LSU_ALIGN_CHECK_EN.
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDLAST,
        S_WR,
        S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        last_idx;
    logic [1:0]        lane;
    logic              op_unsigned;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [23:0]       rd_lanes;
    logic [31:0]       resp_data_q;
    logic              err_q;
    logic              misaligned;
    logic [31:0]       ld_word;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign lane      = cnt - 2'd1;
    assign resp_data = resp_data_q;
    assign resp_err  = err_q;

    // Final byte arrives straight from the RAM during RDLAST; merge it with the captured lanes.
    always_comb begin
        ld_word = 32'd0;
        case (last_idx)
            2'd0:    ld_word = {{24{~op_unsigned & mem_rdata[7]}}, mem_rdata};
            2'd1:    ld_word = {{16{~op_unsigned & mem_rdata[7]}}, mem_rdata, rd_lanes[7:0]};
            default: ld_word = {mem_rdata, rd_lanes[23:0]};
        endcase
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        mem_re     = (state == S_RD);
        mem_we     = (state == S_WR);
        mem_addr   = '0;
        mem_wdata  = 8'd0;
        if ((state == S_RD) || (state == S_WR))
            mem_addr = base + ADDR_W'(cnt);
        if (state == S_WR)
            mem_wdata = wdata[8*cnt +: 8];
        case (state)
            S_IDLE:   if (req_valid) state_nxt = misaligned ? S_RESP : (req_we ? S_WR : S_RD);
            S_RD:     if (cnt == last_idx) state_nxt = S_RDLAST;
            S_RDLAST: state_nxt = S_RESP;
            S_WR:     if (cnt == last_idx) state_nxt = S_RESP;
            S_RESP:   if (resp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            last_idx    <= 2'd0;
            op_unsigned <= 1'b0;
            base        <= '0;
            wdata       <= 32'd0;
            rd_lanes    <= 24'd0;
            resp_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base        <= req_addr;
                        wdata       <= req_wdata;
                        op_unsigned <= req_unsigned;
                        cnt         <= 2'd0;
                        last_idx    <= (req_size == 2'b00) ? 2'd0 :
                                       (req_size == 2'b01) ? 2'd1 : 2'd3;
                        resp_data_q <= 32'd0;
                        err_q       <= misaligned;
                    end
                end
                S_RD: begin
                    cnt <= cnt + 2'd1;
                    // RAM read latency: the byte on mem_rdata belongs to the previous address.
                    if (cnt != 2'd0)
                        rd_lanes[8*lane +: 8] <= mem_rdata;
                end
                S_RDLAST: resp_data_q <= ld_word;
                S_WR:     cnt <= cnt + 2'd1;
                S_RESP: begin
                    if (resp_ready) begin
                        resp_data_q <= 32'd0;
                        err_q       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a 64-byte RAM model
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [5:0]  req_addr = 6'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [5:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  ram [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = 6'd0;
    logic [7:0]  pl_data = 8'd0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_W(6)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge Clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        @(negedge Clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [5:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_lat, input int exp_strobes,
                           input int hold, input logic req_in_resp);
        exp_t e;
        int cyc, nstr, first;
        @(negedge Clk);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        sb.push_back('{exp_data, exp_err, exp_lat});
        cyc = 1; nstr = 0; first = 0;
        while (!resp_valid && cyc < 40) begin
            chk("strobe_excl", mem_re & mem_we, 0);
            if ((mem_re || mem_we) && first == 0) first = cyc;
            nstr += we ? int'(mem_we) : int'(mem_re);
            @(posedge Clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        chk("resp_valid", resp_valid, 1);
        chk("latency", cyc, e.lat);
        chk("strobe_count", nstr, exp_strobes);
        if (exp_strobes > 0) chk("first_strobe_cycle", first, 1);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", resp_err, e.err);
        chk("resp_no_strobe", {mem_re, mem_we}, 0);
        for (int h = 0; h < hold; h++) begin
            chk("resp_req_ready_low", req_ready, 0);
            if (req_in_resp) req_valid = 1'b1;
            @(posedge Clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, e.data);
            chk("hold_err", resp_err, e.err);
        end
        resp_ready = 1'b1;
        @(posedge Clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("drop_valid", resp_valid, 0);
        chk("drop_data", resp_data, 0);
        chk("drop_err", resp_err, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        poke(6'd4, 8'h78); poke(6'd5, 8'h56); poke(6'd6, 8'h34); poke(6'd7, 8'h12);
        poke(6'd8, 8'hFE); poke(6'd9, 8'h80);
        poke(6'h3E, 8'h00); poke(6'h3F, 8'h00); poke(6'h00, 8'h00); poke(6'h01, 8'h00);

        run_req(1'b0, 2'b10, 1'b0, 6'd4, 32'd0, 32'h12345678, 1'b0, 6, 4, 3, 1'b1);
        run_req(1'b0, 2'b01, 1'b0, 6'd8, 32'd0, 32'hFFFF80FE, 1'b0, 4, 2, 0, 1'b0);
        run_req(1'b0, 2'b01, 1'b1, 6'd8, 32'd0, 32'h000080FE, 1'b0, 4, 2, 1, 1'b0);
        run_req(1'b0, 2'b00, 1'b0, 6'd8, 32'd0, 32'hFFFFFFFE, 1'b0, 3, 1, 0, 1'b0);
        run_req(1'b0, 2'b00, 1'b1, 6'd8, 32'd0, 32'h000000FE, 1'b0, 3, 1, 0, 1'b0);
        run_req(1'b0, 2'b11, 1'b0, 6'd4, 32'd0, 32'h12345678, 1'b0, 6, 4, 0, 1'b0);

`ifdef LSU_ALIGN_CHECK_EN
        run_req(1'b1, 2'b10, 1'b0, 6'h3E, 32'hDEADBEEF, 32'd0, 1'b1, 1, 0, 0, 1'b0);
        chk("sw_wrap_untouched", ram[6'h3E], 8'h00);
        run_req(1'b0, 2'b10, 1'b0, 6'd5, 32'd0, 32'd0, 1'b1, 1, 0, 0, 1'b0);
        run_req(1'b0, 2'b01, 1'b0, 6'd9, 32'd0, 32'd0, 1'b1, 1, 0, 0, 1'b0);
`else
        run_req(1'b1, 2'b10, 1'b0, 6'h3E, 32'hDEADBEEF, 32'd0, 1'b0, 5, 4, 0, 1'b0);
        chk("sw_byte_3e", ram[6'h3E], 8'hEF);
        chk("sw_byte_3f", ram[6'h3F], 8'hBE);
        chk("sw_byte_00", ram[6'h00], 8'hAD);
        chk("sw_byte_01", ram[6'h01], 8'hDE);
        run_req(1'b0, 2'b10, 1'b0, 6'd5, 32'd0, 32'hFE123456, 1'b0, 6, 4, 0, 1'b0);
`endif

        run_req(1'b1, 2'b01, 1'b0, 6'h20, 32'hAAAA_C3A5, 32'd0, 1'b0, 3, 2, 0, 1'b0);
        chk("sh_byte0", ram[6'h20], 8'hA5);
        chk("sh_byte1", ram[6'h21], 8'hC3);
        run_req(1'b1, 2'b00, 1'b0, 6'h22, 32'h0000_005A, 32'd0, 1'b0, 2, 1, 0, 1'b0);
        chk("sb_byte", ram[6'h22], 8'h5A);

        poke(6'h10, 8'h00); poke(6'h11, 8'h00); poke(6'h12, 8'h00); poke(6'h13, 8'h00);
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 6'h10;
        req_wdata = 32'h44332211;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        chk("rsw_c1_we", mem_we, 1);
        @(posedge Clk); #1;
        chk("rsw_c2_addr", mem_addr, 6'h11);
        Reset = 1'b1;
        #1;
        chk("rsw_we_drop", mem_we, 0);
        chk("rsw_ready", req_ready, 1);
        chk("rsw_no_resp", resp_valid, 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("rsw_quiet", {resp_valid, mem_we, mem_re}, 0);
        end
        chk("rsw_byte0", ram[6'h10], 8'h11);
        chk("rsw_byte1", ram[6'h11], 8'h00);
        run_req(1'b0, 2'b00, 1'b0, 6'd8, 32'd0, 32'hFFFFFFFE, 1'b0, 3, 1, 0, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
